// File: rtl/sa_feed_ctrl_if.sv
// Bus between the systolic-array feed controller and its host / PE array.
// master = host side (drives the matrices, start and the live PE results),
// slave  = controller side.
interface sa_feed_ctrl_if;
  logic               start;
  logic [71:0]        a_mat;
  logic [71:0]        b_mat;
  logic [143:0]       c_in;
  logic signed [7:0]  a0, a1, a2;
  logic signed [7:0]  b0, b1, b2;
  logic               pe_clr_n;
  logic [143:0]       c_mat;
  logic               busy;
  logic               done;

  modport master (
    output start, a_mat, b_mat, c_in,
    input  a0, a1, a2, b0, b1, b2, pe_clr_n, c_mat, busy, done
  );

  modport slave (
    input  start, a_mat, b_mat, c_in,
    output a0, a1, a2, b0, b1, b2, pe_clr_n, c_mat, busy, done
  );
endinterface

// File: rtl/sa_feed_ctrl.sv
// Feed controller for a 3x3 output-stationary systolic array: latches A/B,
// clears the PE accumulators, streams skewed row/column operands, waits for
// the wavefront to drain, then captures the PE results.

// One operand lane: on each step presents vec[step - LANE] (or 0 outside the
// diagonal band) from a register, so the array sees the classic skewed feed.
module sa_feed_lane #(
  parameter int LANE      = 0,
  parameter int NUM_LANES = 3,
  parameter int VEC_W     = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           feed_nxt,
  input  logic [2:0]                     step_nxt,
  input  logic [NUM_LANES-1:0][VEC_W-1:0] vec,
  output logic [VEC_W-1:0]               op
);
  localparam int IW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  int               d;
  logic [VEC_W-1:0] sel;

  // Select the element owed on the upcoming step; zero outside the band
  always_comb begin
    d   = int'(step_nxt) - LANE;
    sel = '0;
    if (feed_nxt && d >= 0 && d < NUM_LANES)
      sel = vec[d[IW-1:0]];
  end

  // Operand register: outputs never see a combinational input path
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) op <= '0;
    else        op <= sel;
endmodule

module sa_feed_ctrl #(
  parameter int CLR_CYCLES   = 2,
  parameter int DRAIN_CYCLES = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  sa_feed_ctrl_if.slave bus
);
  localparam int NUM_LANES  = 3;
  localparam int VEC_W      = 8;
  localparam int ACC_W      = 16;
  localparam int FEED_STEPS = 2*NUM_LANES - 1;

  localparam logic [3:0] CLR_LAST  = 4'(CLR_CYCLES - 1);
  localparam logic [3:0] DRN_LAST  = 4'(DRAIN_CYCLES - 1);
  localparam logic [3:0] FEED_LAST = 4'(FEED_STEPS - 1);

  generate
    if (CLR_CYCLES < 1 || CLR_CYCLES > 15) begin : g_bad_clr
      $error("sa_feed_ctrl: CLR_CYCLES out of range 1..15");
    end
    if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15) begin : g_bad_drn
      $error("sa_feed_ctrl: DRAIN_CYCLES out of range 1..15");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

  // [row][col][bits] packing lines up with the flat 8*(3r+c) bus layout
  typedef logic [NUM_LANES-1:0][NUM_LANES-1:0][VEC_W-1:0] mat_t;

  state_t state, nxt_state;
  logic [3:0] cnt, nxt_cnt;
  mat_t a_q, b_q, b_col;
  logic [NUM_LANES-1:0][VEC_W-1:0] a_op, b_op;
  logic [NUM_LANES*NUM_LANES*ACC_W-1:0] c_q;
  logic feed_nxt, capture;

  // Column lanes walk B down a column, so present B transposed
  always_comb begin
    b_col = '0;
    for (int r = 0; r < NUM_LANES; r++)
      for (int c = 0; c < NUM_LANES; c++)
        b_col[c][r] = b_q[r][c];
  end

  // Snapshot the operands on the accepting edge so later bus changes are harmless
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (state == IDLE && bus.start) begin
      a_q <= bus.a_mat;
      b_q <= bus.b_mat;
    end

  // State and phase counter registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
    end

  // Next-state: each phase counts its length in cnt, which doubles as the feed step
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    unique case (state)
      IDLE:  if (bus.start) begin nxt_state = CLEAR; nxt_cnt = '0; end
      CLEAR: if (cnt == CLR_LAST) begin nxt_state = FEED; nxt_cnt = '0; end
             else nxt_cnt = cnt + 4'd1;
      FEED:  if (cnt == FEED_LAST) begin nxt_state = DRAIN; nxt_cnt = '0; end
             else nxt_cnt = cnt + 4'd1;
      DRAIN: if (cnt == DRN_LAST) begin nxt_state = DONE; nxt_cnt = '0; end
             else nxt_cnt = cnt + 4'd1;
      DONE:  begin nxt_state = IDLE; nxt_cnt = '0; end
      default: begin nxt_state = IDLE; nxt_cnt = '0; end
    endcase
  end

  // Lanes load from the next state so the registered operand lands in the right step
  assign feed_nxt = (nxt_state == FEED);

  generate
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      sa_feed_lane #(.LANE(l), .NUM_LANES(NUM_LANES), .VEC_W(VEC_W)) u_row (
        .clk(clk), .rst_n(rst_n), .feed_nxt(feed_nxt), .step_nxt(nxt_cnt[2:0]),
        .vec(a_q[l]), .op(a_op[l]));
      sa_feed_lane #(.LANE(l), .NUM_LANES(NUM_LANES), .VEC_W(VEC_W)) u_col (
        .clk(clk), .rst_n(rst_n), .feed_nxt(feed_nxt), .step_nxt(nxt_cnt[2:0]),
        .vec(b_col[l]), .op(b_op[l]));
    end
  endgenerate

  assign capture = (state == DRAIN) && (cnt == DRN_LAST);

  // Result capture on the DRAIN->DONE edge; held until the next run completes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)       c_q <= '0;
    else if (capture) c_q <= bus.c_in;

  assign bus.a0       = a_op[0];
  assign bus.a1       = a_op[1];
  assign bus.a2       = a_op[2];
  assign bus.b0       = b_op[0];
  assign bus.b1       = b_op[1];
  assign bus.b2       = b_op[2];
  assign bus.c_mat    = c_q;
  assign bus.pe_clr_n = (state != CLEAR);
  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
endmodule

// File: doc/sa_feed_ctrl.md
SA_FEED_CTRL -- requirements
Module: sa_feed_ctrl

Interface
REQ-001 Parameter CLR_CYCLES, default 2: cycles the PE-array clear is held asserted; legal range 1..15.
REQ-002 Parameter DRAIN_CYCLES, default 6: cycles waited after the last operand, before capture; legal range 1..15.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  request to run one 3x3 multiply; sampled only in IDLE.
REQ-006 a_mat  in  72  A row-major; A[i][k] at bits 8*(3i+k)+7 : 8*(3i+k); signed 8-bit.
REQ-007 b_mat  in  72  B row-major; B[k][j] at bits 8*(3k+j)+7 : 8*(3k+j); signed 8-bit.
REQ-008 c_in  in  144  live PE-array outputs; c_ij at bits 16*(3i+j)+15 : 16*(3i+j).
REQ-009 a0, a1, a2  out  8 each  signed row operands to the PE array.
REQ-010 b0, b1, b2  out  8 each  signed column operands to the PE array.
REQ-011 pe_clr_n  out  1  active-low accumulator clear to the PE array.
REQ-012 c_mat  out  144  captured result, same packing as c_in.
REQ-013 busy  out  1  high whenever the state is not IDLE.
REQ-014 done  out  1  one-cycle pulse; c_mat is valid from this cycle.

Function
REQ-015 The FSM SHALL have states IDLE, CLEAR, FEED, DRAIN and DONE.
REQ-016 IDLE->CLEAR on a rising edge with start=1; a_mat and b_mat are latched internally on that same edge.
REQ-017 CLEAR: pe_clr_n=0 for exactly CLR_CYCLES cycles, then ->FEED.
REQ-018 FEED: exactly 5 cycles with step t=0..4, then ->DRAIN.
REQ-019 Row operand rule: in FEED step t, a_i = A[i][t-i] if 0<=t-i<=2, else 0.
REQ-020 Column operand rule: in FEED step t, b_j = B[t-j][j] if 0<=t-j<=2, else 0.
REQ-021 a0..a2 and b0..b2 SHALL be 0 in every state other than FEED.
REQ-022 All operand outputs SHALL be registered; no combinational path from any input to any output.
REQ-023 DRAIN: exactly DRAIN_CYCLES cycles, then ->DONE.
REQ-024 On the DRAIN->DONE edge, c_in SHALL be copied to c_mat unchanged (no width or sign change).
REQ-025 c_mat SHALL hold its value until the next capture.
REQ-026 DONE lasts 1 cycle with done=1, then ->IDLE.
REQ-027 start is ignored in all states except IDLE, including DONE; start held high in IDLE begins a new run on the cycle after DONE.
REQ-028 Timing: with the start edge as edge 0, done is high in cycle CLR_CYCLES+5+DRAIN_CYCLES+1 after it (defaults: cycle 14).
REQ-029 a_mat and b_mat changing after the start edge SHALL NOT affect the run in progress.
REQ-030 Out-of-range parameter values SHALL fail elaboration.

Reset
REQ-031 rst_n=0 SHALL immediately, without waiting for clk, force the following: state=IDLE, a0..a2=0, b0..b2=0, pe_clr_n=1, busy=0, done=0, c_mat=0, latched operands=0, counters=0.
REQ-032 Reset asserted mid-run (any state) SHALL abort the run; no done is produced; after release the block waits in IDLE for a new start.

Verification
REQ-033 Golden run. Stimulus: A=[1 2 3;4 5 6;7 8 9], B=[9 6 3;8 5 2;7 4 1], defaults, connected to PE_array. Response: done in cycle 14; c_mat = [46 28 10; 118 73 28; 190 118 46].
REQ-034 Skew check, same stimulus. Response per FEED step (a0,a1,a2 / b0,b1,b2):
- t0: (1,0,0 / 9,0,0)
- t1: (2,4,0 / 8,6,0)
- t2: (3,5,7 / 7,5,3)
- t3: (0,6,8 / 0,4,2)
- t4: (0,0,9 / 0,0,1)
- all operands 0 outside FEED.
REQ-035 Signed run. Stimulus: A=-I, B=[1..9] row-major. Response: c_mat = [-1 -2 -3; -4 -5 -6; -7 -8 -9].
REQ-036 Back-to-back. Stimulus: start held high across two runs with different matrices. Response: the second run starts on the cycle after DONE; pe_clr_n is low for 2 cycles before the second FEED; the second c_mat is free of residue from the first run.
REQ-037 Ignored start. Stimulus: start pulsed during FEED and during DONE. Response: no state change and no extra done pulse.
REQ-038 Reset mid-run. Stimulus: rst_n pulled low during FEED step 2 (asynchronously). Response: outputs go to reset values before the next clock edge; no done pulse; a fresh start then produces a correct golden result.
